// File: rtl/data_unpack_pkg.sv
// data_unpack_pkg: state encoding and default widths for the bit-stream unpacker.
package data_unpack_pkg;
    typedef enum logic [1:0] {FILL, DRAIN, FLUSH} state_t;
    localparam int DEF_IN_W  = 32;
    localparam int DEF_OUT_W = 7;
endpackage

// File: rtl/data_unpack_stream.sv
// data_unpack_stream: re-slices IN_W-bit words into OUT_W-bit packets, LSB first,
// with a flush that emits the zero-padded residue as a final packet.
module data_unpack_stream
    import data_unpack_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    localparam int BUF_W = IN_W + OUT_W - 1,
    localparam int CNT_W = $clog2(BUF_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             flush_done,
    output logic [CNT_W-1:0] fill
);
    if (IN_W < 1 || OUT_W < 1) begin : g_bad_width
        $error("data_unpack_stream: IN_W and OUT_W must be >= 1");
    end

    localparam logic [CNT_W-1:0] IN_C  = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] OUT_C = CNT_W'(OUT_W);

    state_t           r_state;
    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_fill;
    logic             r_flush_pend;
    logic             r_flush_done;
    logic             w_push;
    logic             w_pop;
    logic [BUF_W-1:0] w_shift;
    logic [CNT_W-1:0] w_fill_in;
    logic [CNT_W-1:0] w_fill_out;

    // Handshake outputs decode registered state only, so no input-to-ready path exists.
    assign in_ready   = (r_state == FILL) && !r_flush_pend && (r_fill < OUT_C);
    assign out_valid  = (r_state != FILL);
    assign out_last   = (r_state == FLUSH);
    assign out_data   = r_buf[OUT_W-1:0];
    assign fill       = r_fill;
    assign flush_done = r_flush_done;

    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign w_shift    = BUF_W'(in_data) << r_fill;
    assign w_fill_in  = r_fill + IN_C;
    assign w_fill_out = r_fill - OUT_C;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FILL;
            r_buf        <= '0;
            r_fill       <= '0;
            r_flush_pend <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            r_flush_pend <= r_flush_pend | flush;
            case (r_state)
                FILL: begin
                    if (w_push) begin
                        r_buf  <= r_buf | w_shift;
                        r_fill <= w_fill_in;
                        if (w_fill_in >= OUT_C) r_state <= DRAIN;
                    end else if (r_flush_pend) begin
                        if (r_fill != '0) begin
                            r_state <= FLUSH;
                        end else begin
                            r_flush_pend <= 1'b0;
                            r_flush_done <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop) begin
                        r_buf  <= r_buf >> OUT_W;
                        r_fill <= w_fill_out;
                        if (w_fill_out < OUT_C) r_state <= FILL;
                    end
                end
                FLUSH: begin
                    // Bits above fill are already zero, so the residue is emitted padded.
                    if (w_pop) begin
                        r_buf        <= '0;
                        r_fill       <= '0;
                        r_flush_pend <= 1'b0;
                        r_flush_done <= 1'b1;
                        r_state      <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_data_unpack_stream.sv
// tb_data_unpack_stream: bit-queue reference model plus directed and random stimulus.
module tb_data_unpack_stream;
    localparam int IN_W  = 32;
    localparam int OUT_W = 7;

    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] in_data = '0;
    logic        in_valid = 0;
    logic        in_ready;
    logic        flush = 0;
    logic [6:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        flush_done;
    logic [5:0]  fill;

    logic [7:0]  in_data2 = '0;
    logic        in_valid2 = 0;
    logic        in_ready2;
    logic [11:0] out_data2;
    logic        out_valid2;
    logic        out_last2;
    logic        flush_done2;
    logic [4:0]  fill2;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  done_cnt = 0;
    bit  m_pend = 0;
    bit  q[$];
    logic [7:0] got[$];
    bit  rnd_rdy = 0;
    bit  rdy_force = 1;

    data_unpack_stream dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .flush_done(flush_done), .fill(fill)
    );

    data_unpack_stream #(.IN_W(8), .OUT_W(12)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .flush(1'b0), .out_data(out_data2), .out_valid(out_valid2), .out_ready(1'b1),
        .out_last(out_last2), .flush_done(flush_done2), .fill(fill2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the stream is a queue of bits; packets are its next OUT_W bits.
    always @(negedge clk) begin
        logic [6:0] exp_d;
        bit         last_e;
        if (rst) begin
            q.delete();
            m_pend = 0;
        end else begin
            if (flush_done) begin
                chk("done_pend", m_pend, 1);
                chk("done_empty", q.size(), 0);
                m_pend = 0;
                done_cnt++;
            end
            chk("fill", fill, q.size());
            chk("excl", in_ready && out_valid, 0);
            chk("in_ready", in_ready, !m_pend && q.size() < OUT_W);
            if (q.size() >= OUT_W) chk("latency", out_valid, 1);
            if (out_valid) begin
                last_e = q.size() < OUT_W;
                exp_d = '0;
                for (int i = 0; i < OUT_W && i < q.size(); i++) exp_d[i] = q[i];
                chk("last", out_last, last_e);
                chk("data", out_data, exp_d);
                if (out_ready) begin
                    got.push_back({out_last, out_data});
                    if (last_e) q.delete();
                    else repeat (OUT_W) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) for (int i = 0; i < IN_W; i++) q.push_back(in_data[i]);
            if (flush) m_pend = 1;
        end
    end

    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    task automatic push(input logic [31:0] w, input bit f);
        bit ok = 0;
        in_data = w;
        in_valid = 1;
        flush = f;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
            #1;
            flush = 0;
            if (ok) break;
        end
        in_valid = 0;
        chk("push_timeout", ok, 1);
    endtask

    task automatic flush_pulse();
        flush = 1;
        @(posedge clk);
        #1;
        flush = 0;
    endtask

    task automatic wait_done(input int n0);
        bit ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (done_cnt > n0) begin
                ok = 1;
                break;
            end
        end
        chk("done_timeout", ok, 1);
    endtask

    initial begin
        int n0;
        logic [63:0] acc;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("rst_fill", fill, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", flush_done, 0);
        chk("rst_iready", in_ready, 1);
        @(posedge clk);
        #1;

        // All-ones word then flush: four full packets and a 4-bit residue.
        got.delete();
        n0 = done_cnt;
        push(32'hFFFF_FFFF, 0);
        flush_pulse();
        wait_done(n0);
        chk("ones_cnt", got.size(), 5);
        for (int i = 0; i < 4; i++) chk("ones_pkt", got[i], 8'h7F);
        chk("ones_last", got[4], 8'h8F);
        chk("ones_fill", fill, 0);

        // Bit 0 and bit 63 set: first and tenth packets carry a one.
        got.delete();
        n0 = done_cnt;
        push(32'h0000_0001, 0);
        push(32'h8000_0000, 0);
        flush_pulse();
        wait_done(n0);
        chk("sparse_cnt", got.size(), 10);
        chk("sparse_p0", got[0], 8'h01);
        for (int i = 1; i < 9; i++) chk("sparse_pz", got[i], 8'h00);
        chk("sparse_last", got[9], 8'h81);

        // Backpressure: the first packet must hold still.
        got.delete();
        rdy_force = 0;
        push(32'h1234_5678, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 7'h78);
            chk("bp_fill", fill, 32);
            chk("bp_iready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        rdy_force = 1;
        n0 = done_cnt;
        flush_pulse();
        wait_done(n0);
        chk("bp_cnt", got.size(), 5);
        acc = '0;
        for (int i = 0; i < got.size(); i++) acc |= 64'(got[i][6:0]) << (7 * i);
        chk("bp_word", acc[31:0], 32'h1234_5678);

        // Reset while the second packet is presented.
        push(32'hFFFF_FFFF, 0);
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("mid_fill", fill, 0);
        chk("mid_ovalid", out_valid, 0);
        chk("mid_iready", in_ready, 1);
        chk("mid_done", flush_done, 0);
        @(posedge clk);
        #1;
        got.delete();
        n0 = done_cnt;
        push(32'h0000_0055, 0);
        flush_pulse();
        wait_done(n0);
        chk("mid_cnt", got.size(), 5);
        chk("mid_p0", got[0], 8'h55);
        chk("mid_last", got[4], 8'h80);

        // Flush with an empty buffer: no packet, done within two cycles.
        got.delete();
        n0 = done_cnt;
        flush_pulse();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("empty_done", done_cnt, n0 + 1);
        chk("empty_pkts", got.size(), 0);

        // Narrow-in / wide-out instance.
        in_valid2 = 1;
        in_data2 = 8'hAB;
        @(negedge clk);
        chk("w2_ready0", in_ready2, 1);
        @(posedge clk);
        #1;
        in_data2 = 8'hCD;
        @(negedge clk);
        chk("w2_ready1", in_ready2, 1);
        @(posedge clk);
        #1;
        in_valid2 = 0;
        @(negedge clk);
        chk("w2_valid", out_valid2, 1);
        chk("w2_data", out_data2, 12'hDAB);
        chk("w2_last", out_last2, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("w2_fill", fill2, 4);
        chk("w2_idle", out_valid2, 0);
        @(posedge clk);
        #1;

        // Random words, gaps, backpressure and flushes (some coincident with a push).
        rnd_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            push($urandom, !m_pend && ($urandom_range(0, 7) == 0));
        end
        rnd_rdy = 0;
        rdy_force = 1;
        n0 = done_cnt;
        if (!m_pend) flush_pulse();
        wait_done(n0);
        chk("end_fill", fill, 0);
        chk("end_model", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/data_unpack_stream.md
DATA_UNPACK_STREAM -- requirements
Module: data_unpack_stream

Interface
REQ-001 Parameter IN_W, default 32, input word width in bits (>=1).
REQ-002 Parameter OUT_W, default 7, output packet width in bits (>=1).
REQ-003 Derived constants: BUF_W = IN_W+OUT_W-1 (accumulator width); CNT_W = $clog2(BUF_W+1) (fill-count width).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_data  input  IN_W  input word; bit 0 is the earliest stream bit.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 flush  input  1  single-cycle pulse requesting emission of residual bits.
REQ-010 out_data  output  OUT_W  packet; bit 0 is the earliest stream bit.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  consumer accepts the packet.
REQ-013 out_last  output  1  qualifies out_valid; marks the zero-padded flush packet.
REQ-014 flush_done  output  1  one-cycle pulse when a flush completes.
REQ-015 fill  output  CNT_W  number of valid buffered bits.

Function
REQ-016 Stream ordering: word k contributes stream bits k*IN_W .. k*IN_W+IN_W-1, in LSB order; packet j carries stream bits j*OUT_W .. j*OUT_W+OUT_W-1.
REQ-017 Storage: accumulator buf[BUF_W-1:0] and count fill; invariant: all buf bits at index >= fill are zero.
REQ-018 Input transfer occurs on in_valid && in_ready; buf <= buf | (in_data << fill) and fill <= fill+IN_W.
REQ-019 Output transfer occurs on out_valid && out_ready; buf <= buf >> OUT_W (zero fill) and fill <= fill-OUT_W (0 after a flush packet).
REQ-020 FSM states: FILL, DRAIN, FLUSH; reset state FILL.
REQ-021 FILL: in_ready = !flush_pend && fill < OUT_W; out_valid = 0.
REQ-022 Transition rules from FILL: accepting a word with fill+IN_W >= OUT_W goes to DRAIN; if flush_pend and fill > 0, go to FLUSH; if flush_pend and fill == 0, clear flush_pend and pulse flush_done; otherwise stay in FILL.
REQ-023 DRAIN: out_valid = 1, out_last = 0, out_data = buf[OUT_W-1:0], in_ready = 0; after an output transfer, go to FILL when the new fill < OUT_W.
REQ-024 FLUSH: out_valid = 1, out_last = 1, out_data = buf[OUT_W-1:0] (upper bits zero by REQ-017), in_ready = 0; on transfer fill <= 0, buf <= 0, clear flush_pend, pulse flush_done next cycle, go to FILL.
REQ-025 flush is latched into flush_pend in any state; while flush_pend=1, further flush pulses are absorbed with no extra effect.
REQ-026 Same-cycle flush and input transfer: the word is accepted, then all full packets drain, then the flush packet is emitted.
REQ-027 While out_valid=1 && out_ready=0, out_data, out_last and fill hold stable.
REQ-028 Latency: a word accepted at edge N makes out_valid=1 visible after edge N (the following cycle); packets then stream at one per cycle under continuous out_ready.
REQ-029 No push and pop in the same cycle; in_ready and out_valid are mutually exclusive.
REQ-030 in_ready and out_valid are functions of registered state only, with no combinational path from in_valid, out_ready or flush.
REQ-031 Elaboration fails if IN_W < 1 or OUT_W < 1.

Reset
REQ-032 When rst=1 at a clock edge: buf=0, fill=0, state=FILL, flush_pend=0, out_valid=0, out_last=0, flush_done=0, in_ready=1 in the next cycle.
REQ-033 rst has priority over all transfers; a reset in mid-DRAIN or mid-FLUSH discards buffered bits with no partial packet and no flush_done.

Structure
REQ-034 Package data_unpack_pkg holds the state enum (FILL, DRAIN, FLUSH) and default width constants (32, 7).
REQ-035 Single module with no sub-module; accumulator, fill counter and FSM reside together.

Verification (IN_W=32, OUT_W=7 unless stated)
REQ-036 Word 0xFFFF_FFFF, then flush -> packets 0x7F x4 (out_last=0), then 0x0F with out_last=1, then flush_done pulse; fill returns to 0.
REQ-037 Words 0x0000_0001, 0x8000_0000, then flush -> 9 packets 0x01, 0x00 x8; 10th packet 0x01 with out_last=1.
REQ-038 out_ready held low 5 cycles during DRAIN -> out_data, fill stable; in_ready=0 throughout; no data loss.
REQ-039 rst asserted on the 2nd packet of a word -> next cycle fill=0, out_valid=0, in_ready=1; next word unpacks from bit 0.
REQ-040 flush with fill=0 -> no packet emitted; flush_done pulses within 2 cycles.
REQ-041 IN_W=8, OUT_W=12: words 0xAB, 0xCD -> single packet 0xDAB; fill returns to 4.
